// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// in_ready depends only on the skid flop, rst and flush; it never depends on out_ready.
module pipe_stage_skid_reg #(
  parameter int                DATA_W    = 32,
  parameter int                REG_W     = 5,
  parameter int                PC_W      = 30,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_W-1:0]  in_wdst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_wdst,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] instr_q, instr_d, alu_q, alu_d, sd_q, sd_d;
  logic [REG_W-1:0]  wdst_q, wdst_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d, skid_alu_q, skid_alu_d, skid_sd_q, skid_sd_d;
  logic [REG_W-1:0]  skid_wdst_q, skid_wdst_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_fire, out_fire;

  assign in_ready = ~skid_valid_q & rst & ~flush;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    instr_d      = instr_q;
    alu_d        = alu_q;
    sd_d         = sd_q;
    wdst_d       = wdst_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_alu_d   = skid_alu_q;
    skid_sd_d    = skid_sd_q;
    skid_wdst_d  = skid_wdst_q;
    skid_pc_d    = skid_pc_q;
    stall_d      = stall_q;
    if (flush) begin
      // Bubble injection: data fields other than instr/wdst keep their values.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      instr_d      = NOP_INSTR;
      wdst_d       = '0;
    end else begin
      if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}}))
        stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (skid_valid_q) begin
        if (out_fire) begin
          instr_d      = skid_instr_q;
          alu_d        = skid_alu_q;
          sd_d         = skid_sd_q;
          wdst_d       = skid_wdst_q;
          pc_d         = skid_pc_q;
          skid_valid_d = 1'b0;
        end
      end else if (in_fire && (!main_valid_q || out_fire)) begin
        instr_d      = in_instr;
        alu_d        = in_alu_out;
        sd_d         = in_store_data;
        wdst_d       = in_wdst;
        pc_d         = in_pc;
        main_valid_d = 1'b1;
      end else if (in_fire) begin
        skid_instr_d = in_instr;
        skid_alu_d   = in_alu_out;
        skid_sd_d    = in_store_data;
        skid_wdst_d  = in_wdst;
        skid_pc_d    = in_pc;
        skid_valid_d = 1'b1;
      end else if (out_fire) begin
        main_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      instr_q      <= NOP_INSTR;
      alu_q        <= '0;
      sd_q         <= '0;
      wdst_q       <= '0;
      pc_q         <= '0;
      skid_instr_q <= '0;
      skid_alu_q   <= '0;
      skid_sd_q    <= '0;
      skid_wdst_q  <= '0;
      skid_pc_q    <= '0;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      instr_q      <= instr_d;
      alu_q        <= alu_d;
      sd_q         <= sd_d;
      wdst_q       <= wdst_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_alu_q   <= skid_alu_d;
      skid_sd_q    <= skid_sd_d;
      skid_wdst_q  <= skid_wdst_d;
      skid_pc_q    <= skid_pc_d;
      stall_q      <= stall_d;
    end
  end

  assign out_valid      = main_valid_q;
  assign out_instr      = instr_q;
  assign out_alu_out    = alu_q;
  assign out_store_data = sd_q;
  assign out_wdst       = wdst_q;
  assign out_pc         = pc_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a queue of accepted bundles models the stage,
// plus a second instance with a 4-bit stall counter for saturation.
module tb_pipe_stage_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0020;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  wdst;
    logic [29:0] pc;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_alu_out, in_store_data;
  logic [4:0]  in_wdst;
  logic [29:0] in_pc;
  logic [31:0] out_instr, out_alu_out, out_store_data;
  logic [4:0]  out_wdst;
  logic [29:0] out_pc;
  logic [15:0] stall_cnt;

  logic        d2_flush, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [31:0] d2_out_instr, d2_out_alu_out, d2_out_store_data;
  logic [4:0]  d2_out_wdst;
  logic [29:0] d2_out_pc;
  logic [3:0]  d2_stall_cnt;

  int          errors = 0;
  int          checks = 0;
  bundle_t     sb[$];
  logic [15:0] exp_stall = '0;
  logic        inited = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(32), .REG_W(5), .PC_W(30), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_alu_out(in_alu_out), .in_store_data(in_store_data),
    .in_wdst(in_wdst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_alu_out(out_alu_out), .out_store_data(out_store_data),
    .out_wdst(out_wdst), .out_pc(out_pc), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid_reg #(.DATA_W(32), .REG_W(5), .PC_W(30), .NOP_INSTR(NOP), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush(d2_flush),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_instr(in_instr), .in_alu_out(in_alu_out), .in_store_data(in_store_data),
    .in_wdst(in_wdst), .in_pc(in_pc),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .out_instr(d2_out_instr), .out_alu_out(d2_out_alu_out), .out_store_data(d2_out_store_data),
    .out_wdst(d2_out_wdst), .out_pc(d2_out_pc), .stall_cnt(d2_stall_cnt)
  );

  function automatic bundle_t mk_bundle(int i);
    bundle_t b;
    b.instr = 32'h8C01_0004 + i;
    b.alu   = 32'h1000_0000 + 32'(i * 16);
    b.sd    = 32'hA5A5_0000 + i;
    b.wdst  = 5'(i + 1);
    b.pc    = 30'h100 + 30'(i);
    return b;
  endfunction

  function automatic bundle_t cur_in();
    return {in_instr, in_alu_out, in_store_data, in_wdst, in_pc};
  endfunction

  task automatic set_in(input bundle_t b);
    in_instr      = b.instr;
    in_alu_out    = b.alu;
    in_store_data = b.sd;
    in_wdst       = b.wdst;
    in_pc         = b.pc;
  endtask

  // One clock: scoreboard compare/update at negedge, then return just after the posedge.
  task automatic tick();
    logic    exp_ready, exp_v;
    bundle_t got;
    exp_ready = 1'b0;
    exp_v     = 1'b0;
    @(negedge clk);
    if (inited) begin
      exp_ready = (sb.size() < 2) && rst && !flush;
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL sb_in_ready t=%0t got=%b want=%b", $time, in_ready, exp_ready);
      end
      checks++;
      if (stall_cnt !== exp_stall) begin
        errors++;
        $display("FAIL sb_stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, exp_stall);
      end
      if (rst) begin
        exp_v = (sb.size() > 0);
        checks++;
        if (out_valid !== exp_v) begin
          errors++;
          $display("FAIL sb_out_valid t=%0t got=%b want=%b", $time, out_valid, exp_v);
        end
        if (exp_v) begin
          got = {out_instr, out_alu_out, out_store_data, out_wdst, out_pc};
          checks++;
          if (got !== sb[0]) begin
            errors++;
            $display("FAIL sb_out_fields t=%0t got=%h want=%h", $time, got, sb[0]);
          end
        end
      end
    end
    if (!rst) begin
      sb.delete();
      exp_stall = '0;
      inited    = 1'b1;
    end else if (inited) begin
      if (flush) sb.delete();
      else begin
        if (exp_v && !out_ready && exp_stall != 16'hFFFF) exp_stall++;
        if (exp_v && out_ready) void'(sb.pop_front());
        if (in_valid && exp_ready) sb.push_back(cur_in());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    d2_flush = 1'b0; d2_in_valid = 1'b0; d2_out_ready = 1'b0;
    set_in(mk_bundle(0));
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (out_instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h want=%h", out_instr, NOP); end
    checks++;
    if ({out_alu_out, out_store_data, out_wdst, out_pc} !== '0) begin
      errors++; $display("FAIL reset_fields got=%h want=0", {out_alu_out, out_store_data, out_wdst, out_pc});
    end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d want=0", stall_cnt); end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_pass_through();
    bundle_t b;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = mk_bundle(i);
      set_in(b);
      in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== b.instr || out_pc !== b.pc) begin
        errors++;
        $display("FAIL pass_latency i=%0d got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h",
                 i, out_valid, out_instr, out_pc, b.instr, b.pc);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL pass_drain got v=%b stall=%0d want v=0 stall=0", out_valid, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    bundle_t a, b;
    a = mk_bundle(10);
    b = mk_bundle(11);
    out_ready = 1'b0;
    set_in(a); in_valid = 1'b1;
    tick();
    set_in(b);
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_ready got=%b want=0", in_ready); end
    tick();
    tick();
    checks++;
    if (stall_cnt !== 16'd3 || out_instr !== a.instr || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold got stall=%0d instr=%h want stall=3 instr=%h", stall_cnt, out_instr, a.instr);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_instr !== b.instr || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got v=%b instr=%h rdy=%b want v=1 instr=%h rdy=1",
                         out_valid, out_instr, in_ready, b.instr);
    end
    tick();
  endtask

  task automatic test_flush_skid();
    bundle_t a, b, c;
    a = mk_bundle(20); b = mk_bundle(21); c = mk_bundle(22);
    out_ready = 1'b0;
    set_in(a); in_valid = 1'b1;
    tick();
    set_in(b);
    tick();
    set_in(c); flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_wdst !== 5'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_bubble got v=%b instr=%h wdst=%0d rdy=%b want v=0 instr=%h wdst=0 rdy=1",
                         out_valid, out_instr, out_wdst, in_ready, NOP);
    end
    checks++;
    if (out_alu_out !== a.alu || out_pc !== a.pc || out_store_data !== a.sd) begin
      errors++; $display("FAIL flush_hold got alu=%h pc=%h sd=%h want alu=%h pc=%h sd=%h",
                         out_alu_out, out_pc, out_store_data, a.alu, a.pc, a.sd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_c_dropped got v=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b1;
      set_in(mk_bundle(30 + k)); in_valid = 1'b1;
      tick();
      set_in(mk_bundle(40 + k));
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < 4; j++) tick();
      checks++;
      if (stall_cnt !== 16'd5 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL rstmid_setup k=%0d got stall=%0d rdy=%b v=%b want stall=5 rdy=0 v=1",
                           k, stall_cnt, in_ready, out_valid);
      end
      rst = 1'b0; flush = (k == 1);
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_instr !== NOP || stall_cnt !== 16'd0 ||
          {out_alu_out, out_store_data, out_wdst, out_pc} !== '0) begin
        errors++; $display("FAIL rstmid_state k=%0d got v=%b instr=%h stall=%0d fields=%h want v=0 instr=%h stall=0 fields=0",
                           k, out_valid, out_instr, stall_cnt,
                           {out_alu_out, out_store_data, out_wdst, out_pc}, NOP);
      end
      rst = 1'b1; flush = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_skid_clear k=%0d got=%b want=1", k, in_ready); end
    end
  endtask

  task automatic test_saturation();
    logic [3:0] want;
    in_valid = 1'b0; out_ready = 1'b1;
    set_in(mk_bundle(50));
    d2_in_valid = 1'b1; d2_out_ready = 1'b0;
    tick();
    d2_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      want = (k > 15) ? 4'd15 : 4'(k);
      checks++;
      if (d2_stall_cnt !== want || d2_out_valid !== 1'b1) begin
        errors++; $display("FAIL sat_cnt k=%0d got=%0d v=%b want=%0d v=1", k, d2_stall_cnt, d2_out_valid, want);
      end
    end
  endtask

  task automatic test_random();
    bundle_t b;
    for (int n = 0; n < 3000; n++) begin
      b.instr = $urandom();
      b.alu   = $urandom();
      b.sd    = $urandom();
      b.wdst  = 5'($urandom_range(0, 31));
      b.pc    = 30'($urandom());
      set_in(b);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 5);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_drain got pending=%0d v=%b want pending=0 v=0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_backpressure();
    test_flush_skid();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
